// File: rtl/i2cs_regfile.sv
// I2C slave with a byte register file reachable from both the I2C bus
// (EEPROM-style pointer) and the local register bus, plus a STATUS register.
module i2cs_regfile #(
  parameter int DEPTH    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic       app_clk,
  input  logic       arst_n,
  input  logic       cfg_en,
  input  logic [6:0] cfg_slv_addr,
  input  logic       reg_cs,
  input  logic       reg_wr,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_be,
  output logic [7:0] reg_rdata,
  output logic       reg_ack,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       i2cs_intr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(FILT_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA,
    WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t          state;
  logic [1:0]      scl_sync, sda_sync;
  logic [FW-1:0]   scl_cnt, sda_cnt;
  logic            scl_f, sda_f, scl_d, sda_d;
  logic            scl_rise, scl_fall;
  logic            start_c, stop_c;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [PW-1:0]   ptr;
  logic            ptr_phase;
  logic            stored;
  logic            addr_match;
  logic            wr_done;
  logic [7:0]      rf [DEPTH];
  logic [7:0]      rd_byte;
  logic            i2c_we;
  logic            bus_acc, bus_wr, st_clr, wr_set;
  logic [PW-1:0]   bus_idx;
  logic [7:0]      status;
  logic [7:0]      rd_mux;

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign i2cs_intr    = wr_done;

  // two-flop synchronisers for the pad inputs
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      scl_sync <= '0;
      sda_sync <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad_i};
      sda_sync <= {sda_sync[0], sda_pad_i};
    end
  end

  // accept a new level only after FILT_LEN equal differing samples
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FW'(FILT_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FW'(FILT_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  // previous filtered levels, tracking the filters' idle-high reset
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = cfg_en & scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = cfg_en & scl_f & scl_d & ~sda_d & sda_f;
  assign rd_byte  = rf[ptr];

  assign i2c_we = cfg_en & ~start_c & ~stop_c
                & (state == WR_DATA) & scl_fall
                & (bit_cnt == 4'd8) & ~ptr_phase;

  // protocol FSM: bit counting, pointer, SDA drive
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      ptr          <= '0;
      ptr_phase    <= 1'b0;
      stored       <= 1'b0;
      addr_match   <= 1'b0;
      sda_padoen_o <= 1'b1;
    end else if (!cfg_en) begin
      state        <= IDLE;
      sda_padoen_o <= 1'b1;
    end else if (stop_c) begin
      state        <= IDLE;
      sda_padoen_o <= 1'b1;
      stored       <= 1'b0;
    end else if (start_c) begin
      state        <= ADDR;
      bit_cnt      <= '0;
      addr_match   <= 1'b0;
      sda_padoen_o <= 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg   <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == cfg_slv_addr) begin
              sda_padoen_o <= 1'b0;
              addr_match   <= 1'b1;
              state        <= ADDR_ACK;
            end else begin
              state <= WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt <= '0;
            if (!shreg[0]) begin
              ptr_phase    <= 1'b1;
              sda_padoen_o <= 1'b1;
              state        <= WR_DATA;
            end else begin
              shreg        <= rd_byte;
              sda_padoen_o <= rd_byte[7];
              state        <= RD_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg   <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (ptr_phase) begin
              ptr       <= shreg[PW-1:0];
              ptr_phase <= 1'b0;
            end else begin
              ptr    <= ptr + 1'b1;
              stored <= 1'b1;
            end
            sda_padoen_o <= 1'b0;
            state        <= WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_padoen_o <= 1'b1;
            bit_cnt      <= '0;
            state        <= WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_padoen_o <= 1'b1;
              state        <= RD_ACK;
            end else begin
              shreg        <= {shreg[6:0], 1'b0};
              sda_padoen_o <= shreg[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state <= WAIT_STOP;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end else if (scl_fall) begin
            shreg        <= rd_byte;
            sda_padoen_o <= rd_byte[7];
            bit_cnt      <= '0;
            state        <= RD_DATA;
          end
        end
        WAIT_STOP: sda_padoen_o <= 1'b1;
        default:   state <= IDLE;
      endcase
    end
  end

  assign bus_acc = reg_cs & ~reg_ack;
  assign bus_idx = reg_addr[PW-1:0];
  assign bus_wr  = bus_acc & reg_wr & reg_be
                 & (reg_addr < 4'(DEPTH));
  assign st_clr  = bus_acc & reg_wr & reg_be
                 & (reg_addr == 4'h8) & reg_wdata[0];
  assign wr_set  = stop_c & stored;
  assign status  = {5'b0, addr_match,
                    (state != IDLE), wr_done};

  // register file; the I2C write is last so it wins a collision
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (bus_wr) rf[bus_idx] <= reg_wdata;
      if (i2c_we) rf[ptr] <= shreg;
    end
  end

  // wr_done flag: set has priority over write-1-to-clear
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_done <= 1'b0;
    end else if (wr_set) begin
      wr_done <= 1'b1;
    end else if (st_clr) begin
      wr_done <= 1'b0;
    end
  end

  // register-bus read decode
  always_comb begin
    rd_mux = '0;
    if (reg_addr < 4'(DEPTH)) begin
      rd_mux = rf[bus_idx];
    end else if (reg_addr == 4'h8) begin
      rd_mux = status;
    end
  end

  // one-cycle ack with registered read data
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack <= bus_acc;
      if (bus_acc && !reg_wr) reg_rdata <= rd_mux;
    end
  end

endmodule
